// File: rtl/prco_lsu_pkg.sv
// prco_lsu_pkg: shared ISA opcodes and LSU state encodings for the prco core.
package prco_lsu_pkg;
  localparam logic [4:0] PRCO_OP_ADD = 5'h00;
  localparam logic [4:0] PRCO_OP_LW  = 5'h08;
  localparam logic [4:0] PRCO_OP_SW  = 5'h09;
  typedef enum logic {
    PRCO_LSU_IDLE = 1'b0,
    PRCO_LSU_REQ  = 1'b1
  } lsu_state_e;
  function automatic logic is_mem_op(input logic [4:0] op);
    return op == PRCO_OP_LW || op == PRCO_OP_SW;
  endfunction
endpackage

// File: rtl/prco_lsu.sv
// prco_lsu: single-outstanding load/store unit driving a req/ack data RAM.
// Define PRCO_LSU_TIMEOUT_EN to abort requests left unacknowledged for TIMEOUT_CYCLES.
module prco_lsu
  import prco_lsu_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int REG_W          = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce_ram,
  input  logic [4:0]        i_op,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_W-1:0]  i_rd,
  output logic              q_mem_req,
  output logic              q_mem_we,
  output logic [DATA_W-1:0] q_mem_addr,
  output logic [DATA_W-1:0] q_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              q_ce_wb,
  output logic [REG_W-1:0]  q_wb_reg,
  output logic [DATA_W-1:0] q_wb_data,
  output logic              q_done,
  output logic              q_busy,
  output logic              q_overrun,
  output logic              q_fault
);
  lsu_state_e       state;
  logic [REG_W-1:0] rd_q;
`ifdef PRCO_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  // the count-th REQ edge is reached when cnt already holds count-1
  assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= PRCO_LSU_IDLE;
      rd_q        <= '0;
      q_mem_req   <= 1'b0;
      q_mem_we    <= 1'b0;
      q_mem_addr  <= '0;
      q_mem_wdata <= '0;
      q_ce_wb     <= 1'b0;
      q_wb_reg    <= '0;
      q_wb_data   <= '0;
      q_done      <= 1'b0;
      q_busy      <= 1'b0;
      q_overrun   <= 1'b0;
      q_fault     <= 1'b0;
`ifdef PRCO_LSU_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      q_ce_wb   <= 1'b0;
      q_done    <= 1'b0;
      q_overrun <= 1'b0;
      q_fault   <= 1'b0;
      if (state == PRCO_LSU_IDLE) begin
        if (i_ce_ram && is_mem_op(i_op)) begin
          state       <= PRCO_LSU_REQ;
          rd_q        <= i_rd;
          q_mem_req   <= 1'b1;
          q_busy      <= 1'b1;
          q_mem_we    <= i_op == PRCO_OP_SW;
          q_mem_addr  <= i_addr;
          q_mem_wdata <= i_wdata;
`ifdef PRCO_LSU_TIMEOUT_EN
          cnt         <= '0;
`endif
        end
      end else begin
        q_overrun <= i_ce_ram;
        if (i_mem_ack) begin
          state     <= PRCO_LSU_IDLE;
          q_mem_req <= 1'b0;
          q_busy    <= 1'b0;
          q_done    <= 1'b1;
          q_ce_wb   <= !q_mem_we;
          if (!q_mem_we) begin
            q_wb_reg  <= rd_q;
            q_wb_data <= i_mem_rdata;
          end
        end
`ifdef PRCO_LSU_TIMEOUT_EN
        else if (timeout) begin
          state     <= PRCO_LSU_IDLE;
          q_mem_req <= 1'b0;
          q_busy    <= 1'b0;
          q_done    <= 1'b1;
          q_fault   <= 1'b1;
          q_ce_wb   <= !q_mem_we;
          if (!q_mem_we) begin
            q_wb_reg  <= rd_q;
            q_wb_data <= '0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_prco_lsu.sv
// tb_prco_lsu: directed self-checking bench for prco_lsu.
module tb_prco_lsu;
  import prco_lsu_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_ram = 1'b0;
  logic [4:0]  op = PRCO_OP_ADD;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [2:0]  rd = '0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        ce_wb, done, busy, overrun, fault;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  int checks = 0;
  int failures = 0;
  int txns = 0;

  prco_lsu #(.DATA_W(16), .REG_W(3), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce_ram(ce_ram), .i_op(op), .i_addr(addr),
    .i_wdata(wdata), .i_rd(rd), .q_mem_req(mem_req), .q_mem_we(mem_we),
    .q_mem_addr(mem_addr), .q_mem_wdata(mem_wdata), .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata), .q_ce_wb(ce_wb), .q_wb_reg(wb_reg),
    .q_wb_data(wb_data), .q_done(done), .q_busy(busy), .q_overrun(overrun),
    .q_fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (!rst && mem_req && mem_ack) txns++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] o, input logic [15:0] a, input logic [15:0] w, input logic [2:0] r);
    ce_ram = 1'b1; op = o; addr = a; wdata = w; rd = r;
    tick();
    ce_ram = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if ({mem_req, mem_we, ce_wb, done, busy, overrun, fault} !== 7'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000000", {mem_req, mem_we, ce_wb, done, busy, overrun, fault}); end
    checks++; if ({mem_addr, mem_wdata, wb_data, wb_reg} !== 51'b0) begin failures++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, wb_data, wb_reg}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    issue(PRCO_OP_LW, 16'h0010, 16'h0000, 3'd3);
    checks++; if ({mem_req, busy, mem_we} !== 3'b110) begin failures++; $display("FAIL lw_req got=%b exp=110", {mem_req, busy, mem_we}); end
    checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL lw_addr got=%h exp=0010", mem_addr); end
    tick();
    checks++; if ({mem_req, done, ce_wb} !== 3'b100) begin failures++; $display("FAIL lw_wait got=%b exp=100", {mem_req, done, ce_wb}); end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    checks++; if ({mem_req, busy, ce_wb, done, fault} !== 5'b00110) begin failures++; $display("FAIL lw_done got=%b exp=00110", {mem_req, busy, ce_wb, done, fault}); end
    checks++; if (wb_reg !== 3'd3 || wb_data !== 16'hBEEF) begin failures++; $display("FAIL lw_wb got=%0d/%h exp=3/beef", wb_reg, wb_data); end
    tick();
    checks++; if ({ce_wb, done} !== 2'b00) begin failures++; $display("FAIL lw_pulse got=%b exp=00", {ce_wb, done}); end
    checks++; if (wb_reg !== 3'd3 || wb_data !== 16'hBEEF) begin failures++; $display("FAIL lw_hold got=%0d/%h exp=3/beef", wb_reg, wb_data); end
  endtask

  task automatic test_sw();
    issue(PRCO_OP_SW, 16'h0004, 16'h1234, 3'd6);
    checks++; if ({mem_req, busy, mem_we} !== 3'b111) begin failures++; $display("FAIL sw_req got=%b exp=111", {mem_req, busy, mem_we}); end
    checks++; if (mem_addr !== 16'h0004 || mem_wdata !== 16'h1234) begin failures++; $display("FAIL sw_bus got=%h/%h exp=0004/1234", mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if ({mem_req, busy, ce_wb, done} !== 4'b0001) begin failures++; $display("FAIL sw_done got=%b exp=0001", {mem_req, busy, ce_wb, done}); end
    checks++; if (wb_reg !== 3'd3 || wb_data !== 16'hBEEF) begin failures++; $display("FAIL sw_wb_hold got=%0d/%h exp=3/beef", wb_reg, wb_data); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL sw_pulse got=%b exp=0", done); end
  endtask

  task automatic test_overrun();
    int t0;
    t0 = txns;
    issue(PRCO_OP_LW, 16'h0020, 16'h0000, 3'd1);
    issue(PRCO_OP_SW, 16'h0099, 16'h7777, 3'd2);
    checks++; if ({overrun, mem_req, mem_we} !== 3'b110) begin failures++; $display("FAIL ovr_pulse got=%b exp=110", {overrun, mem_req, mem_we}); end
    checks++; if (mem_addr !== 16'h0020) begin failures++; $display("FAIL ovr_addr got=%h exp=0020", mem_addr); end
    tick();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    checks++; if ({done, ce_wb, wb_reg, wb_data} !== {2'b11, 3'd1, 16'h5555}) begin failures++; $display("FAIL ovr_done got=%b%b/%0d/%h exp=11/1/5555", done, ce_wb, wb_reg, wb_data); end
    checks++; if (txns - t0 !== 1) begin failures++; $display("FAIL ovr_txns got=%0d exp=1", txns - t0); end
    issue(PRCO_OP_SW, 16'h0040, 16'hAAAA, 3'd0);
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0040, 16'hAAAA}) begin failures++; $display("FAIL b2b_req got=%b%b/%h/%h exp=11/0040/aaaa", mem_req, mem_we, mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if ({done, ce_wb, overrun} !== 3'b100) begin failures++; $display("FAIL b2b_done got=%b exp=100", {done, ce_wb, overrun}); end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(PRCO_OP_LW, 16'h0030, 16'h0000, 3'd5);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_req, busy} !== 2'b00) begin failures++; $display("FAIL rstmid_async got=%b exp=00", {mem_req, busy}); end
    tick();
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    checks++; if ({mem_req, busy, done, ce_wb, overrun, fault} !== 6'b0) begin failures++; $display("FAIL rstmid_ack got=%b exp=000000", {mem_req, busy, done, ce_wb, overrun, fault}); end
    tick();
  endtask

  task automatic test_ignored();
    issue(PRCO_OP_ADD, 16'h0050, 16'h2222, 3'd4);
    checks++; if ({mem_req, busy, done, ce_wb, overrun} !== 5'b0) begin failures++; $display("FAIL ign_op got=%b exp=00000", {mem_req, busy, done, ce_wb, overrun}); end
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    tick();
    mem_ack = 1'b0;
    checks++; if ({mem_req, busy, done, ce_wb, wb_data} !== {4'b0, 16'h0000}) begin failures++; $display("FAIL ign_ack got=%b%b%b%b/%h exp=0000/0000", mem_req, busy, done, ce_wb, wb_data); end
    tick();
  endtask

`ifdef PRCO_LSU_TIMEOUT_EN
  task automatic test_timeout();
    issue(PRCO_OP_LW, 16'h0060, 16'h0000, 3'd2);
    mem_rdata = 16'h9999;
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++; if ({mem_req, fault, done} !== 3'b100) begin failures++; $display("FAIL to_wait%0d got=%b exp=100", i, {mem_req, fault, done}); end
    end
    tick();
    checks++; if ({mem_req, busy, fault, done, ce_wb} !== 5'b00111) begin failures++; $display("FAIL to_abort got=%b exp=00111", {mem_req, busy, fault, done, ce_wb}); end
    checks++; if (wb_reg !== 3'd2 || wb_data !== 16'h0000) begin failures++; $display("FAIL to_wb got=%0d/%h exp=2/0000", wb_reg, wb_data); end
    tick();
    issue(PRCO_OP_LW, 16'h0070, 16'h0000, 3'd7);
    tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    checks++; if ({fault, done, ce_wb, wb_data} !== {3'b011, 16'hCAFE}) begin failures++; $display("FAIL to_ackwins got=%b/%h exp=011/cafe", {fault, done, ce_wb}, wb_data); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_overrun();
    test_reset_mid();
    test_ignored();
`ifdef PRCO_LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
